// File: rtl/mcdp_pkg.sv
// Shared types and constants for the multi-cycle accumulator datapath:
// opcodes, FSM states, instruction field positions and register indices.
package mcdp_pkg;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_ADDI = 4'd2,
    OP_LW   = 4'd3,
    OP_SW   = 4'd4,
    OP_BEQ  = 4'd5,
    OP_HALT = 4'd15
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  localparam int INSTR_W = 16;
  localparam int OP_LSB  = 12;
  localparam int OP_W    = 4;
  localparam int RD_LSB  = 10;
  localparam int R1_LSB  = 8;
  localparam int R2_LSB  = 6;
  localparam int RF_W    = 2;
  localparam int IMM_W   = 6;

  localparam int REG_ACC  = 0;
  localparam int REG_ACCO = 1;
  localparam int REG_SP   = 2;
  localparam int REG_RA   = 3;

endpackage

// File: rtl/mcdp_regfile.sv
// NREGS x DATA_W register file: three async read ports for the datapath,
// one async debug read port, one synchronous write port, async clear.
module mcdp_regfile #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [REG_AW-1:0] ra1,
  input  logic [REG_AW-1:0] ra2,
  input  logic [REG_AW-1:0] ra3,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic [DATA_W-1:0] rd3,
  output logic [DATA_W-1:0] dbg_data,
  input  logic              we,
  input  logic [REG_AW-1:0] wa,
  input  logic [DATA_W-1:0] wd
);
  localparam int NREGS = 2**REG_AW;

  logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;

  always_comb begin
    regs_d = regs_q;
    if (we) regs_d[wa] = wd;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) regs_q <= '0;
    else      regs_q <= regs_d;
  end

  assign rd1      = regs_q[ra1];
  assign rd2      = regs_q[ra2];
  assign rd3      = regs_q[ra3];
  assign dbg_data = regs_q[dbg_addr];

endmodule

// File: rtl/mc_accum_datapath.sv
// Multi-cycle 16-bit-instruction datapath with internal sequencing FSM.
// Define MCDP_PERFCNT_EN to add cycle/retire performance counters.
module mc_accum_datapath
  import mcdp_pkg::*;
#(
  parameter int                DATA_W = 16,
  parameter int                REG_AW = 2,
  parameter logic [DATA_W-1:0] RST_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic [DATA_W-1:0] pc,
`ifdef MCDP_PERFCNT_EN
  output logic [31:0]       cyc_cnt,
  output logic [31:0]       ret_cnt,
`endif
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  state_e               state_q, state_d;
  logic [DATA_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   ir_q, ir_d;
  logic [DATA_W-1:0]    a_q, a_d, b_q, b_d, s_q, s_d;
  logic [DATA_W-1:0]    alu_q, alu_d, mdr_q, mdr_d;
  logic                 illegal_q, illegal_d;

  op_e                  op;
  logic [DATA_W-1:0]    imm;
  logic [REG_AW-1:0]    rd_a, r1_a, r2_a;
  logic [DATA_W-1:0]    rf_a, rf_b, rf_s;
  logic                 rf_we;

  assign op   = op_e'(ir_q[OP_LSB +: OP_W]);
  assign imm  = {{(DATA_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  // Register fields are 2 bits wide in the encoding; resize to REG_AW.
  assign rd_a = REG_AW'(ir_q[RD_LSB +: RF_W]);
  assign r1_a = REG_AW'(ir_q[R1_LSB +: RF_W]);
  assign r2_a = REG_AW'(ir_q[R2_LSB +: RF_W]);

  mcdp_regfile #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rf (
    .CLK      (CLK),
    .RST      (RST),
    .ra1      (r1_a),
    .ra2      (r2_a),
    .ra3      (rd_a),
    .dbg_addr (dbg_addr),
    .rd1      (rf_a),
    .rd2      (rf_b),
    .rd3      (rf_s),
    .dbg_data (dbg_data),
    .we       (rf_we),
    .wa       (rd_a),
    .wd       ((op == OP_LW) ? mdr_q : alu_q)
  );

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    alu_d     = alu_q;
    mdr_d     = mdr_q;
    illegal_d = illegal_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    rf_we     = 1'b0;
    case (state_q)
      S_IDLE: if (start) state_d = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        mem_addr = pc_q;
        if (mem_ready) begin
          ir_d    = mem_rdata[INSTR_W-1:0];
          pc_d    = pc_q + DATA_W'(1);
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        a_d     = rf_a;
        b_d     = rf_b;
        s_d     = rf_s;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_ADD:  begin alu_d = a_q + b_q; state_d = S_WB;  end
          OP_SUB:  begin alu_d = a_q - b_q; state_d = S_WB;  end
          OP_ADDI: begin alu_d = a_q + imm; state_d = S_WB;  end
          OP_LW,
          OP_SW:   begin alu_d = a_q + imm; state_d = S_MEM; end
          OP_BEQ: begin
            if (a_q == b_q) pc_d = pc_q + imm;
            state_d = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          default: begin illegal_d = 1'b1; state_d = S_HALT; end
        endcase
      end
      S_MEM: begin
        // Address and store data come from flops, so they hold through waits.
        mem_req   = 1'b1;
        mem_we    = (op == OP_SW);
        mem_addr  = alu_q;
        mem_wdata = s_q;
        if (mem_ready) begin
          mdr_d   = mem_rdata;
          state_d = (op == OP_SW) ? S_FETCH : S_WB;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT: begin
        if (start) begin
          pc_d      = RST_PC;
          illegal_d = 1'b0;
          state_d   = S_FETCH;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q   <= S_IDLE;
      pc_q      <= RST_PC;
      ir_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      s_q       <= '0;
      alu_q     <= '0;
      mdr_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      a_q       <= a_d;
      b_q       <= b_d;
      s_q       <= s_d;
      alu_q     <= alu_d;
      mdr_q     <= mdr_d;
      illegal_q <= illegal_d;
    end
  end

  assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
  assign halted  = (state_q == S_HALT);
  assign illegal = illegal_q;
  assign pc      = pc_q;

`ifdef MCDP_PERFCNT_EN
  logic [31:0] cyc_cnt_q, cyc_cnt_d, ret_cnt_q, ret_cnt_d;
  logic        retire;

  // Retirement: register writeback, store completion, or any branch resolve.
  assign retire = (state_q == S_WB) ||
                  (state_q == S_MEM && op == OP_SW && mem_ready) ||
                  (state_q == S_EXEC && op == OP_BEQ);

  always_comb begin
    cyc_cnt_d = cyc_cnt_q + (busy   ? 32'd1 : 32'd0);
    ret_cnt_d = ret_cnt_q + (retire ? 32'd1 : 32'd0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cyc_cnt_q <= '0;
      ret_cnt_q <= '0;
    end else begin
      cyc_cnt_q <= cyc_cnt_d;
      ret_cnt_q <= ret_cnt_d;
    end
  end

  assign cyc_cnt = cyc_cnt_q;
  assign ret_cnt = ret_cnt_q;
`endif

endmodule

// File: tb/tb_mc_accum_datapath.sv
// Self-checking bench for mc_accum_datapath: directed programs plus random
// programs compared against an instruction-level reference model.
module tb_mc_accum_datapath;

  logic        CLK = 1'b0, RST = 1'b0, start = 1'b0;
  logic        mem_req, mem_we, mem_ready = 1'b1;
  logic [15:0] mem_addr, mem_wdata, mem_rdata, pc, dbg_data;
  logic        busy, halted, illegal;
  logic [1:0]  dbg_addr = 2'd0;
`ifdef MCDP_PERFCNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  mc_accum_datapath dut (
    .CLK(CLK), .RST(RST), .start(start),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .busy(busy), .halted(halted), .illegal(illegal), .pc(pc),
`ifdef MCDP_PERFCNT_EN
    .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt),
`endif
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 CLK = ~CLK;

  logic [15:0] mem [0:65535];
  logic [15:0] mm  [0:65535];
  assign mem_rdata = mem[mem_addr];

  int n_chk = 0, n_pass = 0;
  int rmode = 0, cyc = 0;
  int wr_cnt = 0;
  logic [15:0] wr_addr, wr_data;
  logic [15:0] rd_log[$];
  logic [15:0] prog[$];

  logic [15:0] R[4];
  logic [15:0] exp_pc, exp_rd[$];
  int exp_cyc, exp_wr;
  bit exp_halt, exp_ill;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int r1,
                                      input int r2, input int imm);
    return {op[3:0], rd[1:0], r1[1:0], r2[1:0], imm[5:0]};
  endfunction

  // Instruction-level reference: executes the image in mm, tallies cycles
  // from the per-opcode zero-wait costs.
  task automatic model();
    logic [15:0] p, w, imm, ea;
    int rd, r1, r2;
    R = '{default: 16'd0};
    p = 16'd0; exp_cyc = 0; exp_wr = 0; exp_halt = 0; exp_ill = 0;
    exp_rd.delete();
    for (int s = 0; s < 300 && !exp_halt; s++) begin
      w = mm[p]; exp_rd.push_back(p); p = p + 16'd1;
      rd = int'(w[11:10]); r1 = int'(w[9:8]); r2 = int'(w[7:6]);
      imm = {{10{w[5]}}, w[5:0]};
      case (w[15:12])
        4'd0: begin R[rd] = R[r1] + R[r2]; exp_cyc += 4; end
        4'd1: begin R[rd] = R[r1] - R[r2]; exp_cyc += 4; end
        4'd2: begin R[rd] = R[r1] + imm;   exp_cyc += 4; end
        4'd3: begin ea = R[r1] + imm; exp_rd.push_back(ea); R[rd] = mm[ea]; exp_cyc += 5; end
        4'd4: begin ea = R[r1] + imm; mm[ea] = R[rd]; exp_wr++; exp_cyc += 4; end
        4'd5: begin if (R[r1] == R[r2]) p = p + imm; exp_cyc += 3; end
        4'd15: begin exp_halt = 1; exp_cyc += 3; end
        default: begin exp_ill = 1; exp_halt = 1; exp_cyc += 3; end
      endcase
    end
    exp_pc = p;
  endtask

  task automatic load_prog();
    for (int i = 0; i < 65536; i++) begin mem[i] = 16'd0; mm[i] = 16'd0; end
    foreach (prog[i]) begin mem[i] = prog[i]; mm[i] = prog[i]; end
  endtask

  task automatic do_reset();
    start = 1'b0;
    @(negedge CLK); RST = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic rdreg(input int i, output logic [15:0] v);
    dbg_addr = i[1:0]; #1; v = dbg_data;
  endtask

  task automatic pulse_start();
    @(negedge CLK); start = 1'b1;
    @(negedge CLK); start = 1'b0;
  endtask

  task automatic wait_halt(output int n);
    n = 0;
    while (!halted && n < 3000) begin @(negedge CLK); n++; end
  endtask

  task automatic run_prog(input string nm, input int mode, output int n);
    logic [15:0] v;
    int m;
    rmode = mode;
    do_reset();
    rd_log.delete(); wr_cnt = 0;
    pulse_start();
    wait_halt(n);
    chk({nm, ":halted"}, halted, 1'b1);
    if (mode == 0) chk({nm, ":cycles"}, n, exp_cyc);
    chk({nm, ":pc"}, pc, exp_pc);
    chk({nm, ":illegal"}, illegal, exp_ill);
    for (int r = 0; r < 4; r++) begin
      rdreg(r, v);
      chk($sformatf("%s:R%0d", nm, r), v, R[r]);
    end
    chk({nm, ":nreads"}, rd_log.size(), exp_rd.size());
    m = (rd_log.size() < exp_rd.size()) ? rd_log.size() : exp_rd.size();
    for (int i = 0; i < m; i++) chk($sformatf("%s:rd%0d", nm, i), rd_log[i], exp_rd[i]);
    chk({nm, ":nwrites"}, wr_cnt, exp_wr);
  endtask

  initial begin
    logic [15:0] v;
    int n, k;
    bit pend;
    logic [33:0] held;

    fork
      forever begin
        @(posedge CLK); #1; cyc++;
        case (rmode)
          0: mem_ready = 1'b1;
          1: mem_ready = (cyc % 3 == 0);
          2: mem_ready = 1'($urandom_range(0, 1));
          default: mem_ready = mem_req && !mem_we;
        endcase
      end
      forever begin
        @(posedge CLK);
        if (RST && mem_req && mem_ready) begin
          if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            wr_cnt++; wr_addr = mem_addr; wr_data = mem_wdata;
          end else rd_log.push_back(mem_addr);
        end
      end
      forever begin
        @(negedge CLK);
        if (RST && pend) chk("hold", {mem_req, mem_we, mem_addr, mem_wdata}, held);
        pend = RST && mem_req && !mem_ready;
        held = {mem_req, mem_we, mem_addr, mem_wdata};
      end
    join_none

    // Reset state
    do_reset();
    chk("rst:req", mem_req, 1'b0);
    chk("rst:addr", {mem_we, mem_addr, mem_wdata}, 33'd0);
    chk("rst:busy", {busy, halted, illegal}, 3'd0);
    chk("rst:pc", pc, 16'd0);
    rdreg(0, v); chk("rst:ACC", v, 16'd0);

    // Basic program, zero-wait, then every-3rd-cycle ready
    prog = '{enc(2,0,0,0,5), enc(2,1,0,0,-2), enc(0,2,0,1,0), enc(15,0,0,0,0)};
    for (int md = 0; md < 2; md++) begin
      load_prog(); model();
      run_prog($sformatf("basic%0d", md), md, n);
      if (md == 0) chk("basic:15cyc", n, 15);
      rdreg(0, v); chk("basic:ACC", v, 16'd5);
      rdreg(1, v); chk("basic:ACCO", v, 16'd3);
      rdreg(2, v); chk("basic:SP", v, 16'd8);
      chk("basic:pc4", pc, 16'd4);
    end

    // Store then load
    prog = '{enc(2,0,0,0,25), enc(2,0,0,0,25), enc(4,0,1,0,10), enc(3,3,1,0,10),
             enc(15,0,0,0,0)};
    load_prog(); model();
    run_prog("ldst", 0, n);
    chk("ldst:wcnt", wr_cnt, 1);
    chk("ldst:waddr", wr_addr, 16'd10);
    chk("ldst:wdata", wr_data, 16'd50);
    rdreg(3, v); chk("ldst:RA", v, 16'd50);

    // Branch taken (6->4) then not taken (6->7); SUB wrap
    prog = '{enc(2,0,0,0,12), enc(2,1,1,0,20), enc(1,2,0,1,0), enc(2,1,0,0,-11),
             enc(2,3,3,0,1), enc(0,0,0,3,0), enc(5,0,3,1,-3), enc(15,0,0,0,0)};
    load_prog(); model();
    run_prog("beq", 0, n);
    rdreg(2, v); chk("beq:SPwrap", v, 16'hFFF8);
    chk("beq:pc", pc, 16'd8);
    chk("beq:trace", {rd_log.size() > 10 ? rd_log[7] : 16'hDEAD,
                      rd_log.size() > 10 ? rd_log[10] : 16'hDEAD}, {16'd4, 16'd7});

    // Illegal opcode and restart
    prog = '{enc(2,0,0,0,7), enc(9,0,0,0,0)};
    load_prog(); model();
    run_prog("ill", 0, n);
    chk("ill:flag", {illegal, halted}, 2'b11);
    pulse_start();
    chk("restart:pc", pc, 16'd0);
    chk("restart:flags", {illegal, halted, busy}, 3'b001);
    rdreg(0, v); chk("restart:ACC", v, 16'd7);
    wait_halt(n);
    rdreg(0, v); chk("rerun:ACC", v, 16'd14);
    chk("rerun:ill", illegal, 1'b1);

    // Random programs against the reference model
    for (int t = 0; t < 10; t++) begin
      k = 0;
      do begin
        prog.delete();
        for (int i = 0; i < 14; i++) begin
          int sel, imm;
          sel = $urandom_range(0, 19);
          imm = $urandom_range(0, 63);
          case (sel % 7)
            0, 1: prog.push_back(enc(sel % 2, $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,3), 0));
            2, 3: prog.push_back(enc(2, $urandom_range(0,3), $urandom_range(0,3), 0, imm));
            4:    prog.push_back(enc(3, $urandom_range(0,3), $urandom_range(0,3), 0, imm));
            5:    prog.push_back(enc(4, $urandom_range(0,3), $urandom_range(0,3), 0, imm));
            default: prog.push_back(sel == 20 ? enc(9,0,0,0,0)
                                              : enc(5, 0, $urandom_range(0,3), $urandom_range(0,3), $urandom_range(0,2)));
          endcase
        end
        prog.push_back(enc(15,0,0,0,0)); prog.push_back(enc(15,0,0,0,0));
        load_prog(); model(); k++;
      end while (!exp_halt && k < 20);
      if (exp_halt) run_prog($sformatf("rnd%0d", t), (t % 2 == 0) ? 0 : 2, n);
    end

    // Async reset during a stalled store
    prog = '{enc(2,0,0,0,9), enc(4,0,1,0,5), enc(15,0,0,0,0)};
    load_prog();
    rmode = 3;
    do_reset();
    wr_cnt = 0;
    pulse_start();
    n = 0;
    while (!mem_we && n < 50) begin @(negedge CLK); n++; end
    chk("arst:reachedMEM", {mem_we, mem_addr, mem_wdata}, {1'b1, 16'd5, 16'd9});
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    #1;
    chk("arst:req", {mem_req, mem_we}, 2'b00);
    chk("arst:bus", {mem_addr, mem_wdata}, 32'd0);
    chk("arst:state", {busy, halted, illegal}, 3'd0);
    chk("arst:pc", pc, 16'd0);
    @(negedge CLK); RST = 1'b1;
    repeat (3) @(negedge CLK);
    chk("arst:idle", {busy, mem_req}, 2'b00);
    chk("arst:nowrite", wr_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
